// File: rtl/winograd_pkg.sv
// Shared tile geometry, scale constants and position type for the Winograd path.
package winograd_pkg;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned TILE_ROWS   = 8;
  localparam int unsigned TILE_COLS   = 10;
  localparam int unsigned SCALE_SHIFT = 6;
  localparam int unsigned SCALE_ODD   = 9;
  localparam int unsigned ROW_W       = 3;
  localparam int unsigned COL_W       = 4;
  localparam int unsigned PROD_W      = DATA_W + 4;
  localparam int unsigned SCALED_W    = DATA_W + 10;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } tile_pos_t;

  function automatic logic is_tile_last(tile_pos_t p);
    return (p.row == ROW_W'(TILE_ROWS - 1)) && (p.col == COL_W'(TILE_COLS - 1));
  endfunction

endpackage

// File: rtl/tile_pos_counter.sv
// Row-major (row, col) position counter for one tile, with early-resync support.
module tile_pos_counter
  import winograd_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      advance,
  input  logic      resync,
  output tile_pos_t pos,
  output logic      is_last_c
);

  assign is_last_c = is_tile_last(pos);

  // Resync and end-of-tile both restart at (0,0); otherwise step column then row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= '0;
    end else if (advance) begin
      if (resync || is_last_c) begin
        pos <= '0;
      end else if (pos.col == COL_W'(TILE_COLS - 1)) begin
        pos.col <= '0;
        pos.row <= pos.row + ROW_W'(1);
      end else begin
        pos.col <= pos.col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/winograd_tile_scale_576.sv
// Element-serial x576 saturating pre-scaler: two-stage valid/ready pipe with tile framing.
module winograd_tile_scale_576
  import winograd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ROW_W-1:0]  out_row,
  output logic [COL_W-1:0]  out_col,
  output logic              out_last,
  output logic              out_sat,
  output logic              tile_sat,
  output logic              frame_err
);

  logic                ready_en;
  logic                s1_valid;
  logic [PROD_W-1:0]   s1_prod;
  tile_pos_t           s1_pos;
  logic                sat_acc;

  tile_pos_t           in_pos;
  logic                in_is_last_c;
  logic                in_fire_c;
  logic                resync_c;
  logic                s2_load_c;
  logic [PROD_W-1:0]   prod9_c;
  logic [SCALED_W-1:0] scaled_c;
  logic                sat_c;
  logic                pos_last_c;

  // ready_en keeps in_ready low while reset is held and for the first cycle after.
  assign in_ready   = ready_en && !(s1_valid && out_valid && !out_ready);
  assign in_fire_c  = in_valid && in_ready;
  assign s2_load_c  = s1_valid && (!out_valid || out_ready);
  assign resync_c   = in_fire_c && in_last && !in_is_last_c;

  assign prod9_c    = PROD_W'(in_data) * PROD_W'(SCALE_ODD);
  assign scaled_c   = SCALED_W'(s1_prod) << SCALE_SHIFT;
  assign sat_c      = |scaled_c[SCALED_W-1:DATA_W];
  assign pos_last_c = is_tile_last(s1_pos);

  tile_pos_counter u_in_pos (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance   (in_fire_c),
    .resync    (resync_c),
    .pos       (in_pos),
    .is_last_c (in_is_last_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      ready_en  <= 1'b1;
      frame_err <= in_fire_c && (in_last != in_is_last_c);
    end
  end

  // Stage 1: x9 product with the element's tile position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_pos   <= '0;
    end else begin
      s1_valid <= in_fire_c || (s1_valid && !s2_load_c);
      if (in_fire_c) begin
        s1_prod <= prod9_c;
        s1_pos  <= in_pos;
      end
    end
  end

  // Stage 2: <<6, saturate, and fold saturation into the per-tile sticky flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
      tile_sat  <= 1'b0;
      sat_acc   <= 1'b0;
    end else begin
      out_valid <= s2_load_c || (out_valid && !out_ready);
      if (s2_load_c) begin
        out_data <= sat_c ? '1 : scaled_c[DATA_W-1:0];
        out_sat  <= sat_c;
        out_row  <= s1_pos.row;
        out_col  <= s1_pos.col;
        out_last <= pos_last_c;
        tile_sat <= pos_last_c && (sat_acc || sat_c);
        sat_acc  <= !pos_last_c && (sat_acc || sat_c);
      end
    end
  end

endmodule

// File: tb/tb_winograd_tile_scale_576.sv
// Directed bench for winograd_tile_scale_576: scoreboard plus hand-computed checkpoints.
module tb_winograd_tile_scale_576;

  typedef struct packed {
    logic [15:0] d;
    logic [2:0]  r;
    logic [3:0]  c;
    logic        l;
    logic        s;
    logic        ts;
  } pkt_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [2:0]  out_row;
  logic [3:0]  out_col;
  logic        out_last;
  logic        out_sat;
  logic        tile_sat;
  logic        frame_err;

  int   vecs = 0;
  int   errs = 0;
  pkt_t exp_q[$];
  logic [2:0] m_row;
  logic [3:0] m_col;
  logic       m_acc;
  logic       ov, ir, fe;

  winograd_tile_scale_576 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .out_sat   (out_sat),
    .tile_sat  (tile_sat),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic string fmt(pkt_t p);
    return $sformatf("d=%0d rc=(%0d,%0d) last=%0b sat=%0b tsat=%0b", p.d, p.r, p.c, p.l, p.s, p.ts);
  endfunction

  function automatic logic mlast();
    return (m_row == 3'd7) && (m_col == 4'd9);
  endfunction

  // Reference: x576 in 32-bit arithmetic, clamp, and tag with the bench's own tile counter.
  function automatic void push_exp(logic [15:0] d, logic l);
    pkt_t        e;
    int unsigned p;
    p    = 32'(d) * 32'd576;
    e.s  = (p > 32'd65535);
    e.d  = e.s ? 16'hFFFF : 16'(p);
    e.r  = m_row;
    e.c  = m_col;
    e.l  = mlast();
    e.ts = e.l && (m_acc || e.s);
    m_acc = !e.l && (m_acc || e.s);
    if ((l && !e.l) || e.l) begin
      m_row = '0;
      m_col = '0;
    end else if (m_col == 4'd9) begin
      m_col = '0;
      m_row = m_row + 3'd1;
    end else begin
      m_col = m_col + 4'd1;
    end
    exp_q.push_back(e);
  endfunction

  task automatic step(input logic v, input logic [15:0] d, input logic l, input logic r,
                      output logic ifire, output logic ofire, output pkt_t o);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    @(negedge clk);
    ifire = in_valid && in_ready;
    ofire = out_valid && out_ready;
    ov = out_valid;
    ir = in_ready;
    fe = frame_err;
    o  = {out_data, out_row, out_col, out_last, out_sat, tile_sat};
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    m_row = '0;
    m_col = '0;
    m_acc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if ({out_valid, in_ready, out_data, out_row, out_col, out_last, out_sat, tile_sat, frame_err} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: got valid=%0b ready=%0b %0d, want all zero", out_valid, in_ready, out_data);
    end
    rst_n = 1'b1;
    #1;
    vecs++;
    if (in_ready !== 1'b0) begin
      errs++;
      $display("FAIL reset_ready_early: got %0b want 0", in_ready);
    end
    @(posedge clk);
    #1;
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_ready_late: got %0b want 1", in_ready);
    end
  endtask

  task automatic test_stream();
    int   sent = 0, nout = 0, nlast = 0, first_k = -1, last_k = -1;
    logic inf, of, dl;
    pkt_t o, e;
    do_reset();
    for (int k = 0; k < 90; k++) begin
      dl = mlast();
      step(sent < 80, 16'(sent), dl, 1'b1, inf, of, o);
      if (of) begin
        vecs++;
        nout++;
        if (first_k < 0) first_k = k;
        last_k = k;
        if (o.l) nlast++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL stream_out: unexpected %s", fmt(o));
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin
            errs++;
            $display("FAIL stream_out: got %s want %s", fmt(o), fmt(e));
          end
        end
      end
      if (inf) begin
        push_exp(16'(sent), dl);
        sent++;
      end
    end
    vecs++;
    if (first_k != 2) begin errs++; $display("FAIL stream_latency: got %0d want 2", first_k); end
    vecs++;
    if (last_k != 81) begin errs++; $display("FAIL stream_last_cycle: got %0d want 81", last_k); end
    vecs++;
    if (nout != 80) begin errs++; $display("FAIL stream_count: got %0d want 80", nout); end
    vecs++;
    if (nlast != 1) begin errs++; $display("FAIL stream_out_last: got %0d want 1", nlast); end
  endtask

  task automatic test_saturation();
    int          sent = 0, n = 0;
    logic        inf, of, dl;
    logic [15:0] dd;
    pkt_t        o, e;
    do_reset();
    for (int k = 0; k < 170; k++) begin
      dl = mlast();
      dd = (sent == 5) ? 16'd113 : (sent == 6) ? 16'd114 : (sent == 7) ? 16'hFFFF : 16'(sent % 100);
      step(sent < 160, dd, dl, 1'b1, inf, of, o);
      if (of) begin
        vecs++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL sat_out: unexpected %s", fmt(o));
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin
            errs++;
            $display("FAIL sat_out: got %s want %s", fmt(o), fmt(e));
          end
        end
        if (n == 5 || n == 6 || n == 7 || n == 79 || n == 159) begin
          vecs++;
          if ((n == 5 && (o.d !== 16'd65088 || o.s !== 1'b0)) ||
              ((n == 6 || n == 7) && (o.d !== 16'd65535 || o.s !== 1'b1)) ||
              (n == 79 && (o.l !== 1'b1 || o.ts !== 1'b1)) ||
              (n == 159 && (o.l !== 1'b1 || o.ts !== 1'b0))) begin
            errs++;
            $display("FAIL sat_point_%0d: got %s", n, fmt(o));
          end
        end
        n++;
      end
      if (inf) begin
        push_exp(dd, dl);
        sent++;
      end
    end
    vecs++;
    if (n != 160) begin errs++; $display("FAIL sat_count: got %0d want 160", n); end
  endtask

  task automatic test_random_stall();
    int          sent = 0;
    logic        inf, of, dl, r, stalled = 1'b0;
    logic [15:0] dd;
    pkt_t        o, e, prev = '0;
    do_reset();
    for (int k = 0; k < 3000 && !(sent == 240 && exp_q.size() == 0); k++) begin
      r  = 1'($urandom_range(0, 1));
      dd = 16'($urandom_range(0, 200));
      dl = mlast();
      step(sent < 240, dd, dl, r, inf, of, o);
      if (stalled) begin
        vecs++;
        if (!ov || o !== prev) begin
          errs++;
          $display("FAIL stall_hold: got valid=%0b %s want %s", ov, fmt(o), fmt(prev));
        end
      end
      stalled = ov && !r;
      prev = o;
      if (of) begin
        vecs++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL random_out: unexpected %s", fmt(o));
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin
            errs++;
            $display("FAIL random_out: got %s want %s", fmt(o), fmt(e));
          end
        end
      end
      if (inf) begin
        push_exp(dd, dl);
        sent++;
      end
    end
    vecs++;
    if (sent != 240 || exp_q.size() != 0) begin
      errs++;
      $display("FAIL random_drain: sent %0d pending %0d, want 240 and 0", sent, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int          sent = 0, acc = 0, nout = 0;
    logic        inf, of, dl;
    logic [15:0] dd;
    pkt_t        o, e;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      dl = mlast();
      dd = 16'(sent * 7 + 1);
      step(1'b1, dd, dl, 1'b0, inf, of, o);
      if (inf) begin
        push_exp(dd, dl);
        sent++;
        acc++;
      end
    end
    vecs++;
    if (acc != 2) begin errs++; $display("FAIL stall_accept: got %0d want 2", acc); end
    vecs++;
    if (ir !== 1'b0) begin errs++; $display("FAIL stall_ready: got %0b want 0", ir); end
    for (int k = 0; k < 30; k++) begin
      dl = mlast();
      dd = 16'(sent * 7 + 1);
      step(k < 20, dd, dl, 1'b1, inf, of, o);
      if (of) begin
        vecs++;
        if (k < 20) nout++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL b2b_out: unexpected %s", fmt(o));
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin
            errs++;
            $display("FAIL b2b_out: got %s want %s", fmt(o), fmt(e));
          end
        end
      end
      if (inf) begin
        push_exp(dd, dl);
        sent++;
      end
    end
    vecs++;
    if (nout != 20) begin errs++; $display("FAIL b2b_no_bubble: got %0d want 20", nout); end
    vecs++;
    if (exp_q.size() != 0) begin errs++; $display("FAIL b2b_drain: pending %0d want 0", exp_q.size()); end
  endtask

  task automatic test_frame_err();
    int   sent = 0, n = 0, nfe = 0, fe_k = -1, k40 = -1, nlast = 0, last_n = -1;
    logic inf, of, dl;
    pkt_t o, e;
    do_reset();
    for (int k = 0; k < 130; k++) begin
      dl = (sent == 40) ? 1'b1 : mlast();
      step(sent < 121, 16'(sent), dl, 1'b1, inf, of, o);
      if (fe) begin
        nfe++;
        fe_k = k;
      end
      if (of) begin
        vecs++;
        if (o.l) begin nlast++; last_n = n; end
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL frame_out: unexpected %s", fmt(o));
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin
            errs++;
            $display("FAIL frame_out: got %s want %s", fmt(o), fmt(e));
          end
        end
        if (n == 41) begin
          vecs++;
          if (o.r !== 3'd0 || o.c !== 4'd0) begin
            errs++;
            $display("FAIL frame_resync_tag: got (%0d,%0d) want (0,0)", o.r, o.c);
          end
        end
        n++;
      end
      if (inf) begin
        if (sent == 40) k40 = k;
        push_exp(16'(sent), dl);
        sent++;
      end
    end
    vecs++;
    if (nfe != 1 || fe_k != k40 + 1) begin
      errs++;
      $display("FAIL frame_err_pulse: got %0d pulses at %0d, want 1 at %0d", nfe, fe_k, k40 + 1);
    end
    vecs++;
    if (nlast != 1 || last_n != 120) begin
      errs++;
      $display("FAIL frame_out_last: got %0d at index %0d, want 1 at 120", nlast, last_n);
    end
  endtask

  task automatic test_reset_midtile();
    int   sent = 0, n = 0;
    logic inf, of, dl;
    pkt_t o, e;
    do_reset();
    for (int k = 0; k < 60 && sent < 51; k++) begin
      dl = mlast();
      step(1'b1, 16'd200, dl, 1'b1, inf, of, o);
      if (of) begin
        vecs++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL prereset_out: unexpected %s", fmt(o));
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin
            errs++;
            $display("FAIL prereset_out: got %s want %s", fmt(o), fmt(e));
          end
        end
      end
      if (inf) begin
        push_exp(16'd200, dl);
        sent++;
      end
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({out_valid, in_ready, out_data, out_row, out_col, out_last, out_sat, tile_sat, frame_err} !== '0) begin
      errs++;
      $display("FAIL midreset_async: got valid=%0b ready=%0b d=%0d, want all zero", out_valid, in_ready, out_data);
    end
    @(posedge clk);
    #1;
    vecs++;
    if ({out_valid, in_ready, out_data, out_row, out_col, out_last, out_sat, tile_sat, frame_err} !== '0) begin
      errs++;
      $display("FAIL midreset_edge: got valid=%0b ready=%0b d=%0d, want all zero", out_valid, in_ready, out_data);
    end
    exp_q.delete();
    m_row = '0;
    m_col = '0;
    m_acc = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sent = 0;
    for (int k = 0; k < 90; k++) begin
      dl = mlast();
      step(sent < 80, 16'd3, dl, 1'b1, inf, of, o);
      if (of) begin
        vecs++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL postreset_out: unexpected %s", fmt(o));
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin
            errs++;
            $display("FAIL postreset_out: got %s want %s", fmt(o), fmt(e));
          end
        end
        if (n == 0 || n == 79) begin
          vecs++;
          if ((n == 0 && (o.r !== 3'd0 || o.c !== 4'd0 || o.ts !== 1'b0)) ||
              (n == 79 && (o.l !== 1'b1 || o.ts !== 1'b0))) begin
            errs++;
            $display("FAIL postreset_point_%0d: got %s", n, fmt(o));
          end
        end
        n++;
      end
      if (inf) begin
        push_exp(16'd3, dl);
        sent++;
      end
    end
    vecs++;
    if (n != 80) begin errs++; $display("FAIL postreset_count: got %0d want 80", n); end
  endtask

  initial begin
    m_row = '0;
    m_col = '0;
    m_acc = 1'b0;
    test_reset();
    test_stream();
    test_saturation();
    test_random_stall();
    test_back_to_back();
    test_frame_err();
    test_reset_midtile();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
